// File: rtl/knn_pkg.sv
// Shared k-NN constants: FSM encoding, SEL geometry and the vote-count width helper.
// KNN_VOTE_WEIGHT_EN selects rank-weighted voting (rank i adds K-i) instead of one vote per rank.
package knn_pkg;

  localparam int K_MAX = 16;
  localparam int SEL_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_ACC_LAST = 3'd3;
  localparam logic [2:0] ST_SCAN     = 3'd4;
  localparam logic [2:0] ST_FIN      = 3'd5;

`ifdef KNN_VOTE_WEIGHT_EN
  localparam bit VOTE_WEIGHTED = 1'b1;
`else
  localparam bit VOTE_WEIGHTED = 1'b0;
`endif

  // Width of a bin counter: must hold the largest possible total for one class.
  function automatic int cnt_w(input int k, input bit weighted);
    return weighted ? $clog2(k * (k + 1) / 2 + 1) : $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// NCLASS-bin vote counter bank with parallel clear and one combinational read port.
module knn_vote_hist #(
  parameter int NCLASS = 16,
  parameter int CW     = 4,
  localparam int IW    = $clog2(NCLASS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc_en,
  input  logic [IW-1:0] idx,
  input  logic [CW-1:0] inc_amount,
  input  logic [IW-1:0] rd_idx,
  output logic [CW-1:0] rd_cnt
);

  logic [NCLASS-1:0][CW-1:0] bin_q;

  for (genvar b = 0; b < NCLASS; b++) begin : g_bin
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              bin_q[b] <= '0;
      else if (clear)                        bin_q[b] <= '0;
      else if (inc_en && idx == IW'(b))      bin_q[b] <= bin_q[b] + inc_amount;
    end
  end

  assign rd_cnt = bin_q[rd_idx];

endmodule

// File: rtl/knn_vote_reader.sv
// Reads the sorted neighbour labels back from the k-NN sorter, histograms them and reports
// the majority class. KNN_VOTE_WEIGHT_EN enables rank-weighted votes.
module knn_vote_reader
  import knn_pkg::*;
#(
  parameter int  K       = 10,
  parameter int  LABEL_W = 8,
  parameter int  NCLASS  = 16,
  localparam int CW      = cnt_w(K, VOTE_WEIGHTED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [SEL_W-1:0]   sel,
  input  logic [LABEL_W-1:0] data_in,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] class_out,
  output logic [CW-1:0]      count_out,
  output logic               error
);

  localparam int IW = $clog2(NCLASS);

  logic [2:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [IW-1:0]      scan_q, scan_d;
  logic [IW-1:0]      best_idx_q, best_idx_d;
  logic [CW-1:0]      best_cnt_q, best_cnt_d;
  logic [LABEL_W-1:0] class_q, class_d;
  logic [CW-1:0]      count_q, count_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               acc_en, lbl_ok, inc_en, better;
  logic [SEL_W-1:0]   rank;
  logic [CW-1:0]      inc_amt, rd_cnt;

  // data_in lags sel by one cycle, so the label on the bus belongs to rank sel-1.
  assign acc_en = (state_q == ST_READ && sel_q != '0) || state_q == ST_ACC_LAST;
  assign rank   = (state_q == ST_ACC_LAST) ? SEL_W'(K - 1) : sel_q - 1'b1;
  assign lbl_ok = {1'b0, data_in} < (LABEL_W + 1)'(NCLASS);
  assign inc_en = acc_en && lbl_ok;

`ifdef KNN_VOTE_WEIGHT_EN
  assign inc_amt = CW'(K) - CW'(rank);
`else
  assign inc_amt = CW'(1);
`endif

  knn_vote_hist #(
    .NCLASS(NCLASS),
    .CW    (CW)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == ST_CLEAR),
    .inc_en    (inc_en),
    .idx       (data_in[IW-1:0]),
    .inc_amount(inc_amt),
    .rd_idx    (scan_q),
    .rd_cnt    (rd_cnt)
  );

  // Strictly-greater update keeps the lowest index on ties.
  assign better = rd_cnt > best_cnt_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    class_d    = class_q;
    count_d    = count_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        err_d      = 1'b0;
        sel_d      = '0;
        scan_d     = '0;
        best_idx_d = '0;
        best_cnt_d = '0;
        state_d    = ST_READ;
      end
      ST_READ: begin
        if (sel_q == SEL_W'(K - 1)) begin
          sel_d   = '0;
          state_d = ST_ACC_LAST;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      ST_ACC_LAST: begin
        scan_d  = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (better) begin
          best_idx_d = scan_q;
          best_cnt_d = rd_cnt;
        end
        // Results are captured on entry to FIN so they are valid alongside done.
        if (scan_q == IW'(NCLASS - 1)) begin
          class_d = LABEL_W'(better ? scan_q : best_idx_q);
          count_d = better ? rd_cnt : best_cnt_q;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (acc_en && !lbl_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      class_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      class_q    <= class_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign class_out = class_q;
  assign count_out = count_q;
  assign error     = err_q;

endmodule

// File: tb/tb_knn_vote_reader.sv
// Directed bench for knn_vote_reader with a one-cycle registered sorter read model.
module tb_knn_vote_reader;
  import knn_pkg::*;

  localparam int  K  = 10;
  localparam int  LW = 8;
  localparam int  NC = 16;
  localparam int  CW = cnt_w(K, VOTE_WEIGHTED);
  localparam bit  W  = VOTE_WEIGHTED;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    sel;
  logic [LW-1:0] data_in;
  logic          busy, done, error;
  logic [LW-1:0] class_out;
  logic [CW-1:0] count_out;
  logic [LW-1:0] lab [16];

  int nvec = 0;
  int nbad = 0;

  knn_vote_reader #(.K(K), .LABEL_W(LW), .NCLASS(NC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sel      (sel),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .class_out(class_out),
    .count_out(count_out),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_in <= lab[sel];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, act, want);
    end
  endtask

  task automatic set_lab(input int split, input int lo, input int hi);
    for (int i = 0; i < 16; i++) lab[i] = LW'((i < split) ? lo : hi);
  endtask

  // Start a vote; cycle n is the state after the n-th edge following the sampling edge.
  task automatic run_vote(input string tag, input int restart_at,
                          input int want_cls, input int want_cnt, input int want_err);
    int done_cyc = -1;
    int ndone = 0;
    int busy_bad = 0;
    int sel_bad = 0;
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (busy !== (n <= 29)) busy_bad++;
      if (sel !== 4'((n >= 2 && n <= 11) ? n - 2 : 0)) sel_bad++;
    end
    start = 1'b0;
    chk({tag, "/done_cyc"}, done_cyc, 29);
    chk({tag, "/ndone"}, ndone, 1);
    chk({tag, "/busy"}, busy_bad, 0);
    chk({tag, "/sel"}, sel_bad, 0);
    chk({tag, "/class"}, class_out, want_cls);
    chk({tag, "/count"}, count_out, want_cnt);
    chk({tag, "/error"}, error, want_err);
  endtask

  initial begin
    int act;
    set_lab(16, 0, 0);
    #2;
    chk("rst/sel", sel, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/class", class_out, 0);
    chk("rst/count", count_out, 0);
    chk("rst/error", error, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    set_lab(16, 3, 3);
    run_vote("basic", 0, 3, W ? 55 : 10, 0);

    set_lab(5, 7, 2);
    run_vote("tie", 0, W ? 7 : 2, W ? 40 : 5, 0);

    set_lab(16, 200, 200);
    run_vote("allbad", 0, 0, 0, 1);

    set_lab(4, 4, 6);
    run_vote("weight", 0, W ? 4 : 6, W ? 34 : 6, 0);

    set_lab(16, 5, 5);
    lab[4] = 8'd20;
    run_vote("badlbl", 0, 5, W ? 49 : 9, 1);

    // Abort mid-READ at sel=5 (cycle 7).
    set_lab(16, 3, 3);
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort/sel_pre", sel, 5);
    rst = 1'b0;
    #1;
    chk("abort/sel", sel, 0);
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/class", class_out, 0);
    chk("abort/count", count_out, 0);
    chk("abort/error", error, 0);
    @(negedge clk); rst = 1'b1;
    act = 0;
    repeat (35) begin
      @(negedge clk);
      if (done || busy) act++;
    end
    chk("abort/quiet", act, 0);
    run_vote("after_abort", 0, 3, W ? 55 : 10, 0);

    set_lab(4, 4, 6);
    run_vote("restart_busy", 10, W ? 4 : 6, W ? 34 : 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
